// File: rtl/slc3_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// slc3_mul_sequencer_if
// Request/result bundle between the ISDU (master) and the shift-add
// multiplier sequencer (slave) used by the SLC-3 MUL instruction.
//
// Signals
//   Start       master->slave  request pulse, only honoured while idle
//   A, B        master->slave  multiplicand / multiplier (SR1 / SR2 values)
//   Busy        slave->master  high while the multiply iterates
//   Done        slave->master  one-cycle completion pulse
//   Product_lo  slave->master  low half of A*B (registered)
//   Product_hi  slave->master  high half of unsigned A*B (registered)
//
// WIDTH must match the WIDTH of the attached slc3_mul_sequencer.
// ---------------------------------------------------------------------------
interface slc3_mul_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Product_lo;
    logic [WIDTH-1:0] Product_hi;

    modport master (
        output Start, A, B,
        input  Busy, Done, Product_lo, Product_hi
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, Product_lo, Product_hi
    );
endinterface

// File: rtl/slc3_mul_sequencer.sv
// ---------------------------------------------------------------------------
// slc3_mul_sequencer
// Multi-cycle shift-add multiplier for the SLC-3 MUL instruction. The ISDU
// pulses Start with the two register-file operands, waits for Done, then
// routes Product_lo to the DR writeback path.
//
// Ports
//   Clk    in  system clock, all state on the rising edge
//   Reset  in  synchronous, active-high; clears all state, drops any op
//   bus    slave modport of slc3_mul_sequencer_if (Start/A/B in,
//          Busy/Done/Product_lo/Product_hi out)
//
// Configuration
//   MUL_EARLY_TERM_EN  when defined, RUN also ends as soon as the remaining
//                      multiplier bits are all zero; results are unchanged,
//                      only latency shrinks. Undefined: always WIDTH cycles.
//
// Timing (default build): Start accepted at edge t, Busy high for WIDTH
// cycles, Done high for the single cycle after that, then back to idle.
// Product_lo is the correct two's-complement low half for signed operands
// as well; Product_hi is only meaningful as the unsigned high half.
// ---------------------------------------------------------------------------
module slc3_mul_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    slc3_mul_sequencer_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   prod_lo;
    logic [WIDTH-1:0]   prod_hi;
    logic               last_iter;
    logic               busy;
    logic               done;

    // Accumulator value after this cycle's conditional add. The full product
    // fits in 2*WIDTH bits, so no carry out of the adder is ever lost.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

`ifdef MUL_EARLY_TERM_EN
    // Stop once no set multiplier bits remain above the one consumed now.
    assign last_iter = (count == CW'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
    assign last_iter = (count == CW'(WIDTH - 1));
`endif

    // State register.
    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand / accumulator datapath and result registers.
    // NOTE: these are ordinary flops, not a memory array, so clearing them
    // all on reset is cheap and makes the post-reset state fully defined.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            prod_lo <= '0;
            prod_hi <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.A};
                        mplier <= bus.B;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        // Results move only here, so they hold through
                        // idle, new requests and the next RUN.
                        prod_hi <= acc_next[2*WIDTH-1:WIDTH];
                        prod_lo <= acc_next[WIDTH-1:0];
                    end
                end
                default: begin
                    // DONE: nothing to update; Start here is dropped.
                end
            endcase
        end
    end

    assign bus.Busy       = busy;
    assign bus.Done       = done;
    assign bus.Product_lo = prod_lo;
    assign bus.Product_hi = prod_hi;

endmodule

// File: tb/tb_slc3_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_slc3_mul_sequencer
// Directed self-checking bench for slc3_mul_sequencer (WIDTH = 16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected latency follows MUL_EARLY_TERM_EN if the bench is built with it.
// ---------------------------------------------------------------------------
module tb_slc3_mul_sequencer;

    localparam int WIDTH = 16;

    logic Clk;
    logic Reset;

    slc3_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    slc3_mul_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] prev_lo = '0;
    logic [WIDTH-1:0] prev_hi = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of RUN cycles the sequencer should spend for multiplier b.
    function automatic int exp_runs(input logic [WIDTH-1:0] b);
        int n;
        n = WIDTH;
`ifdef MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 1; i < WIDTH; i++) begin
            if (b[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Present a request for one edge; returns at the next falling edge,
    // which is the first RUN cycle when the request is accepted.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    // Called on the falling edge of the first RUN cycle. Checks Busy every
    // cycle, result hold during RUN, RUN length and final products. If
    // repulse_at > 0, Start is raised with 9*9 after that many RUN cycles.
    // Returns on the falling edge of the Done cycle.
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] exp_lo,
                               input logic [WIDTH-1:0] exp_hi,
                               input int repulse_at);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.Done) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
            check({tag, "_hold_lo"}, 32'(bus.Product_lo), 32'(prev_lo));
            n++;
            if (n == repulse_at) begin
                bus.Start = 1'b1;
                bus.A     = 16'd9;
                bus.B     = 16'd9;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge Clk);
        end
        bus.Start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_run_cycles"}, 32'(n), 32'(exp_runs(b)));
        check({tag, "_busy_in_done"}, 32'(bus.Busy), 32'd0);
        check({tag, "_lo"}, 32'(bus.Product_lo), 32'(exp_lo));
        check({tag, "_hi"}, 32'(bus.Product_hi), 32'(exp_hi));
        prev_lo = exp_lo;
        prev_hi = exp_hi;
    endtask

    // Step one cycle past Done and confirm the pulse was a single cycle.
    task automatic after_done(input string tag);
        @(negedge Clk);
        check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset state (Start high during reset must not start anything).
        repeat (3) @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 16'd3;
        bus.B     = 16'd5;
        @(negedge Clk);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_lo",   32'(bus.Product_lo), 32'd0);
        check("rst_hi",   32'(bus.Product_hi), 32'd0);
        bus.Start = 1'b0;
        Reset     = 1'b0;
        @(negedge Clk);
        check("post_rst_busy", 32'(bus.Busy), 32'd0);

        // 3*5, with Start re-pulsed mid-run with 9*9 (must be ignored).
        issue(16'd3, 16'd5);
        wait_result("mul3x5", 16'd5, 16'h000F, 16'h0000, 4);

        // Start during the Done cycle is dropped; held one more cycle it
        // is accepted from IDLE.
        bus.Start = 1'b1;
        bus.A     = 16'd2;
        bus.B     = 16'd3;
        @(negedge Clk);
        check("start_in_done_busy", 32'(bus.Busy), 32'd0);
        check("start_in_done_done", 32'(bus.Done), 32'd0);
        @(negedge Clk);
        bus.Start = 1'b0;
        wait_result("mul2x3", 16'd3, 16'h0006, 16'h0000, 0);
        after_done("mul2x3");

        // Result holds across idle cycles.
        repeat (5) @(negedge Clk);
        check("idle_hold_lo", 32'(bus.Product_lo), 32'h0006);

        // Back-to-back operations.
        issue(16'd3, 16'd5);
        wait_result("mul3x5b", 16'd5, 16'h000F, 16'h0000, 0);
        after_done("mul3x5b");
        issue(16'hFFFF, 16'hFFFF);
        wait_result("mulffff", 16'hFFFF, 16'h0001, 16'hFFFE, 0);
        after_done("mulffff");
        issue(16'hFFFD, 16'h0007);
        wait_result("mulneg3x7", 16'h0007, 16'hFFEB, 16'h0006, 0);
        after_done("mulneg3x7");

        // Multiplier boundaries: zero, top bit only, one.
        issue(16'h1234, 16'h0000);
        wait_result("mulb0", 16'h0000, 16'h0000, 16'h0000, 0);
        issue(16'd3, 16'h8000);
        wait_result("mulb8000", 16'h8000, 16'h8000, 16'h0001, 0);
        issue(16'd7, 16'd3);
        wait_result("mul7x3", 16'd3, 16'h0015, 16'h0000, 0);
        issue(16'hABCD, 16'h0001);
        wait_result("mulb1", 16'h0001, 16'hABCD, 16'h0000, 0);

        // Reset in the middle of an operation.
        issue(16'd3, 16'h8005);
        repeat (6) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        check("midrst_done", 32'(bus.Done), 32'd0);
        check("midrst_lo",   32'(bus.Product_lo), 32'd0);
        check("midrst_hi",   32'(bus.Product_hi), 32'd0);
        prev_lo = '0;
        prev_hi = '0;
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (bus.Done || bus.Busy) done_seen = 1'b1;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        issue(16'd2, 16'd2);
        wait_result("mul2x2", 16'd2, 16'h0004, 16'h0000, 0);
        after_done("mul2x2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
